// File: rtl/red_pipe.sv
// red_pipe: 3-stage dual-modulus (8380417 / 3329) Barrett reducer with valid/ready
// handshake, pass-through tag and a single global advance enable.
module red_pipe #(
   parameter int TAG_W    = 4,
   parameter bit EN_KYBER = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [45:0]      operand_i,
   input  logic             mode_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [22:0]      result_o,
   output logic [TAG_W-1:0] tag_o
);
   localparam logic [24:0] Q_DIL = 25'd8380417;
   localparam logic [24:0] Q_KYB = 25'd3329;
   logic             en, kyb;
   logic [69:0]      xd, prod_dil;
   logic [36:0]      xk, prod_kyb;
   logic [23:0]      qhat_d, qhat_q;
   logic [24:0]      x_d, x_q, qh, qq_dil, qq_kyb, r_d, r_q, q_sel, s_a, s_b;
   logic [22:0]      res_d, res_q;
   logic             v1_q, m1_q, v2_q, m2_q, v3_q;
   logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

   assign en         = !v3_q | out_ready_i;
   assign in_ready_o = en;
   assign kyb        = EN_KYBER & mode_i;

   // 8396807 = 2^23 + 2^13 + 2^2 + 2^1 + 2^0 ; 5039 = 2^12+2^9+2^8+2^7+2^5+2^3+2^2+2^1+2^0
   assign xd       = {24'd0, operand_i};
   assign xk       = {13'd0, operand_i[23:0]};
   assign prod_dil = (xd << 23) + (xd << 13) + (xd << 2) + (xd << 1) + xd;
   assign prod_kyb = (xk << 12) + (xk << 9) + (xk << 8) + (xk << 7) + (xk << 5)
                   + (xk << 3) + (xk << 2) + (xk << 1) + xk;
   assign qhat_d   = kyb ? 24'(prod_kyb >> 24) : 24'(prod_dil >> 46);
   assign x_d      = kyb ? {1'b0, operand_i[23:0]} : operand_i[24:0];

   // r < 3q < 2^25, so the product qhat*q is only needed modulo 2^25
   assign qh     = {1'b0, qhat_q};
   assign qq_dil = (qh << 23) - (qh << 13) + qh;
   assign qq_kyb = (qh << 11) + (qh << 10) + (qh << 8) + qh;
   assign r_d    = x_q - (m1_q ? qq_kyb : qq_dil);

   assign q_sel = m2_q ? Q_KYB : Q_DIL;
   assign s_a   = (r_q >= q_sel) ? r_q - q_sel : r_q;
   assign s_b   = (s_a >= q_sel) ? s_a - q_sel : s_a;
   assign res_d = 23'(s_b);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v1_q   <= 1'b0;
         m1_q   <= 1'b0;
         x_q    <= '0;
         qhat_q <= '0;
         tag1_q <= '0;
         v2_q   <= 1'b0;
         m2_q   <= 1'b0;
         r_q    <= '0;
         tag2_q <= '0;
         v3_q   <= 1'b0;
         res_q  <= '0;
         tag3_q <= '0;
      end else if (en) begin
         v1_q   <= in_valid_i;
         m1_q   <= kyb;
         x_q    <= x_d;
         qhat_q <= qhat_d;
         tag1_q <= tag_i;
         v2_q   <= v1_q;
         m2_q   <= m1_q;
         r_q    <= r_d;
         tag2_q <= tag1_q;
         v3_q   <= v2_q;
         res_q  <= res_d;
         tag3_q <= tag2_q;
      end
   end

   assign out_valid_o = v3_q;
   assign result_o    = res_q;
   assign tag_o       = tag3_q;
endmodule

// File: tb/tb_red_pipe.sv
// tb_red_pipe: scoreboard bench for red_pipe; directed, random, interleave,
// back-pressure and mid-stream reset scenarios.
module tb_red_pipe;
   localparam int TAG_W = 4;
   logic             clk_i = 1'b0, rst_ni = 1'b0, in_valid_i = 1'b0, mode_i = 1'b0, out_ready_i = 1'b1;
   logic             in_ready_o, out_valid_o;
   logic [45:0]      operand_i = '0;
   logic [TAG_W-1:0] tag_i = '0, tag_o;
   logic [22:0]      result_o;
   int               errors = 0, checks = 0, n_out = 0;
   logic [26:0]      sb_q[$];
   logic [26:0]      exp_v;
   logic             stall_q = 1'b0;
   logic [22:0]      hold_res;
   logic [TAG_W-1:0] hold_tag;

   red_pipe #(.TAG_W(TAG_W), .EN_KYBER(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .operand_i(operand_i), .mode_i(mode_i), .tag_i(tag_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .result_o(result_o), .tag_o(tag_o));

   always #5 clk_i = ~clk_i;

   function automatic logic [22:0] ref_mod(input logic [45:0] x, input logic md);
      logic [23:0] lo;
      lo = x[23:0];
      return md ? 23'(lo % 24'd3329) : 23'(x % 46'd8380417);
   endfunction

   // Output monitor: handshake rule, stall stability and in-order scoreboard
   always @(negedge clk_i) begin
      if (rst_ni) begin
         checks++;
         if (in_ready_o !== (!out_valid_o | out_ready_i)) begin
            errors++;
            $display("FAIL in_ready rule: got %b want %b", in_ready_o, !out_valid_o | out_ready_i);
         end
         if (stall_q) begin
            checks++;
            if (out_valid_o !== 1'b1 || result_o !== hold_res || tag_o !== hold_tag) begin
               errors++;
               $display("FAIL stall hold: got v=%b r=%0d t=%0d want v=1 r=%0d t=%0d",
                        out_valid_o, result_o, tag_o, hold_res, hold_tag);
            end
         end
         if (out_valid_o && out_ready_i) begin
            checks++;
            n_out++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected output: got r=%0d t=%0d want none", result_o, tag_o);
            end else begin
               exp_v = sb_q.pop_front();
               if ({result_o, tag_o} !== exp_v) begin
                  errors++;
                  $display("FAIL result: got r=%0d t=%0d want r=%0d t=%0d",
                           result_o, tag_o, exp_v[26:4], exp_v[3:0]);
               end
            end
         end
         stall_q  = out_valid_o && !out_ready_i;
         hold_res = result_o;
         hold_tag = tag_o;
      end else stall_q = 1'b0;
   end

   task automatic send(input logic [45:0] op, input logic md, input logic [TAG_W-1:0] tg,
                       input logic [22:0] exp);
      logic ok;
      int n;
      operand_i  = op;
      mode_i     = md;
      tag_i      = tg;
      in_valid_i = 1'b1;
      n = 0;
      do begin
         @(negedge clk_i);
         ok = in_ready_o;
         @(posedge clk_i);
         #1;
         n++;
      end while (!ok && n < 200);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send timeout: got in_ready=0 for %0d cycles want 1", n);
      end else sb_q.push_back({exp, tg});
      in_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", sb_q.size());
      end
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   // Rising edges from presentation (accept edge included) until out_valid_o
   task automatic check_latency(input string nm);
      int lat;
      lat = 1;
      while (!out_valid_o && lat < 20) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL latency %s: got %0d want 3", nm, lat);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_i);
      #1;
      checks += 4;
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", out_valid_o); end
      if (result_o !== 23'd0) begin errors++; $display("FAIL reset result: got %0d want 0", result_o); end
      if (tag_o !== '0) begin errors++; $display("FAIL reset tag: got %0d want 0", tag_o); end
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready_o); end
      #2 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b want 1", in_ready_o); end
   endtask

   task automatic test_dilithium();
      logic [45:0] x;
      logic md;
      send(46'd70231389093888, 1'b0, 4'd5, 23'd8380416);
      check_latency("dil_max");
      drain();
      send(46'h3FFF_FFFF_FFFF, 1'b0, 4'd9, 23'd49144);
      drain();
      send(46'd8380417, 1'b0, 4'd1, 23'd0);
      send(46'd8380416, 1'b0, 4'd2, 23'd8380416);
      send(46'd0, 1'b0, 4'd3, 23'd0);
      drain();
      for (int i = 0; i < 2000; i++) begin
         x  = {$urandom, $urandom};
         md = ($urandom_range(0, 3) == 0);
         send(x, md, 4'($urandom), ref_mod(x, md));
      end
      drain();
   endtask

   task automatic test_kyber();
      send(46'd11075584, 1'b1, 4'd2, 23'd1);
      send({22'h3FFFFF, 24'hFFFFFF}, 1'b1, 4'd3, 23'd2384);
      send(46'd3329, 1'b1, 4'd4, 23'd0);
      send(46'd3328, 1'b1, 4'd5, 23'd3328);
      drain();
   endtask

   task automatic test_interleave();
      send(46'd70231389093888, 1'b0, 4'd1, 23'd8380416);
      send(46'd11075584, 1'b1, 4'd2, 23'd1);
      send(46'd8380417, 1'b0, 4'd3, 23'd0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL interleave valid %0d: got %b want 1", i, out_valid_o);
         end
         @(posedge clk_i);
         #1;
      end
      drain();
   endtask

   task automatic test_backpressure();
      int n0;
      logic done;
      logic [45:0] x;
      logic md;
      n0   = n_out;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               x  = {$urandom, $urandom};
               md = $urandom_range(0, 1) == 1;
               send(x, md, 4'(i), ref_mod(x, md));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk_i);
               #1;
               out_ready_i = ($urandom_range(0, 2) == 0);
            end
         end
      join
      out_ready_i = 1'b1;
      drain();
      checks++;
      if (n_out - n0 != 8) begin
         errors++;
         $display("FAIL backpressure count: got %0d want 8", n_out - n0);
      end
   endtask

   task automatic test_reset_midstream();
      out_ready_i = 1'b1;
      send(46'd123456789, 1'b0, 4'd7, 23'd0);
      send(46'd987654, 1'b1, 4'd8, 23'd0);
      send(46'd5555555555, 1'b0, 4'd9, 23'd0);
      rst_ni = 1'b0;
      #1;
      checks += 3;
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midreset valid: got %b want 0", out_valid_o); end
      if (result_o !== 23'd0) begin errors++; $display("FAIL midreset result: got %0d want 0", result_o); end
      if (tag_o !== '0) begin errors++; $display("FAIL midreset tag: got %0d want 0", tag_o); end
      sb_q.delete();
      @(posedge clk_i);
      #2 rst_ni = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i);
         #1;
         checks++;
         if (out_valid_o !== 1'b0) begin errors++; $display("FAIL stale output %0d: got %b want 0", i, out_valid_o); end
      end
      send(46'd70231389093888, 1'b0, 4'd6, 23'd8380416);
      check_latency("after_reset");
      drain();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_dilithium();
      test_kyber();
      test_interleave();
      test_backpressure();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
